// File: rtl/usb_data_buffer.sv
// ---------------------------------------------------------------------------
// usb_data_buffer
//
// Shared byte FIFO between the USB RX control unit, the TX encoder and the
// AHB-Lite slave.
//
// Writers (RX wins if both strobe in the same cycle):
//   rx_store_packet_data / rx_packet_data   RX control unit (received bytes)
//   store_tx_data        / tx_data          AHB side (bytes to transmit)
// Readers (TX wins if both strobe in the same cycle):
//   get_tx_packet_data -> tx_packet_data    TX encoder, registered
//   get_rx_data        -> rx_data           AHB side, registered
// Control:
//   clk, rst (synchronous, active-high)
//   flush (RX control, on DATA PID), clear (AHB software request)
//   Both reset the pointers; the read-data registers keep their values.
// Status:
//   buffer_occupancy  bytes stored, 0..DEPTH (registered)
//   full, empty       decoded from buffer_occupancy
//
// Optional build macro USB_BUFFER_ERR_EN adds sticky error flags:
//   overflow   write strobe while full, or both write strobes at once
//   underflow  read strobe while empty
// Both are cleared by rst, flush or clear.
// ---------------------------------------------------------------------------
module usb_data_buffer #(
  parameter int DEPTH = 64,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_store_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  input  logic             get_tx_packet_data,
  input  logic             flush,
  input  logic             clear,
  output logic [7:0]       rx_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             full,
  output logic             empty
`ifdef USB_BUFFER_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];

  logic [OCC_W-1:0] wptr_q, wptr_d;
  logic [OCC_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             ptr_reset;
  logic             wr_req, rd_req;
  logic             wr_en, rd_en;
  logic [7:0]       wr_byte;
  logic [7:0]       rd_byte;

  // Status is decoded from the registered occupancy, so a read and a write in
  // the same cycle both see the pre-edge level: at full the read wins, at
  // empty the write wins.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    full      = (occ_q == OCC_W'(DEPTH));
    empty     = (occ_q == '0);
    ptr_reset = flush | clear;
    wr_req    = rx_store_packet_data | store_tx_data;
    rd_req    = get_tx_packet_data | get_rx_data;
    wr_en     = wr_req && !full  && !ptr_reset;
    rd_en     = rd_req && !empty && !ptr_reset;
    wr_byte   = rx_store_packet_data ? rx_packet_data : tx_data;
    rd_byte   = mem[rptr_q[IDX_W-1:0]];

    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rx_data_d = rx_data_q;
    tx_data_d = tx_data_q;

    if (ptr_reset) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + OCC_W'(1);
      if (rd_en) begin
        rptr_d = rptr_q + OCC_W'(1);
        if (get_tx_packet_data) tx_data_d = rd_byte;
        else                    rx_data_d = rd_byte;
      end
    end

    // The wrap bit makes the modular difference exact for 0..DEPTH.
    occ_d = wptr_d - rptr_d;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      rx_data_q <= '0;
      tx_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      rx_data_q <= rx_data_d;
      tx_data_q <= tx_data_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through pointers that reset, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wptr_q[IDX_W-1:0]] <= wr_byte;
  end

  assign rx_data          = rx_data_q;
  assign tx_packet_data   = tx_data_q;
  assign buffer_occupancy = occ_q;

`ifdef USB_BUFFER_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A collision of both writers counts as overflow because the AHB byte is
  // lost. A pointer reset in the same cycle wins over a new error.
  always_comb begin
    overflow_d  = overflow_q  | (wr_req && full)
                              | (rx_store_packet_data && store_tx_data);
    underflow_d = underflow_q | (rd_req && empty);
    if (ptr_reset) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_data_buffer
//
// Self-checking bench for usb_data_buffer. A queue-based reference model
// tracks the stored bytes, the two read-data registers and the error flags;
// each scenario task drives stimulus one cycle at a time and compares the
// DUT outputs (sampled on the falling edge) against the model or constants.
// ---------------------------------------------------------------------------
module tb_usb_data_buffer;

  localparam int DEPTH = 64;
  localparam int OCC_W = 7;
  localparam int VEC_W = OCC_W + 18;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_store_packet_data;
  logic [7:0]       rx_packet_data;
  logic             store_tx_data;
  logic [7:0]       tx_data;
  logic             get_rx_data;
  logic             get_tx_packet_data;
  logic             flush;
  logic             clear;
  logic [7:0]       rx_data;
  logic [7:0]       tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             full;
  logic             empty;
`ifdef USB_BUFFER_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  usb_data_buffer #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_store_packet_data (rx_store_packet_data),
    .rx_packet_data       (rx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .flush                (flush),
    .clear                (clear),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .full                 (full),
    .empty                (empty)
`ifdef USB_BUFFER_ERR_EN
    ,
    .overflow             (overflow),
    .underflow            (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  byte unsigned q[$];
  logic [7:0]   m_rx;
  logic [7:0]   m_tx;
  bit           m_ovf;
  bit           m_unf;

  wire [VEC_W-1:0] dut_vec = {buffer_occupancy, full, empty, rx_data, tx_packet_data};

  function automatic logic [VEC_W-1:0] model_vec();
    logic [OCC_W-1:0] occ;
    occ = OCC_W'(q.size());
    return {occ, q.size() == DEPTH, q.size() == 0, m_rx, m_tx};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_update();
    bit         was_full;
    bit         was_empty;
    byte unsigned b;
    if (rst) begin
      q.delete();
      m_rx  = 8'h00;
      m_tx  = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (flush || clear) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (((rx_store_packet_data || store_tx_data) && was_full) ||
          (rx_store_packet_data && store_tx_data)) m_ovf = 1'b1;
      if ((get_rx_data || get_tx_packet_data) && was_empty) m_unf = 1'b1;
      if ((get_rx_data || get_tx_packet_data) && !was_empty) begin
        b = q.pop_front();
        if (get_tx_packet_data) m_tx = b;
        else                    m_rx = b;
      end
      if ((rx_store_packet_data || store_tx_data) && !was_full)
        q.push_back(rx_store_packet_data ? rx_packet_data : tx_data);
    end
  endtask

  task automatic idle_inputs();
    rst                  = 1'b0;
    rx_store_packet_data = 1'b0;
    rx_packet_data       = 8'h00;
    store_tx_data        = 1'b0;
    tx_data              = 8'h00;
    get_rx_data          = 1'b0;
    get_tx_packet_data   = 1'b0;
    flush                = 1'b0;
    clear                = 1'b0;
  endtask

  // Drive one cycle of stimulus (called on a falling edge), update the model,
  // and return on the next falling edge with the inputs idle.
  task automatic drive(input logic rs_i, input logic [7:0] rx_b,
                       input logic st_i, input logic [7:0] tx_b,
                       input logic grx_i, input logic gtx_i,
                       input logic fl_i, input logic cl_i, input logic rst_i);
    rx_store_packet_data = rs_i;
    rx_packet_data       = rx_b;
    store_tx_data        = st_i;
    tx_data              = tx_b;
    get_rx_data          = grx_i;
    get_tx_packet_data   = gtx_i;
    flush                = fl_i;
    clear                = cl_i;
    rst                  = rst_i;
    model_update();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    // Put something in the buffer first so the reset has work to undo.
    drive(1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
    do_reset();
    drive(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0);
    checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", buffer_occupancy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_packet_data); end
`ifdef USB_BUFFER_ERR_EN
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
`endif
  endtask

  task automatic test_basic_rx_read();
    do_reset();
    drive(1, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 0);
    drive(1, 8'h3C, 0, 8'h00, 0, 0, 0, 0, 0);
    checks++; if (buffer_occupancy !== 7'd2) begin errors++; $display("FAIL basic_occ2 got=%0d exp=2", buffer_occupancy); end
    drive(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_rd1 got=%h exp=a5", rx_data); end
    drive(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rd2 got=%h exp=3c", rx_data); end
    checks++; if ({buffer_occupancy, empty} !== {7'd0, 1'b1}) begin errors++; $display("FAIL basic_occ0 got=%0d/%b exp=0/1", buffer_occupancy, empty); end
  endtask

  task automatic test_fill_overflow();
    int bad;
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 8'h00, 0, 0, 0, 0, 0);
    checks++; if ({buffer_occupancy, full} !== {7'd64, 1'b1}) begin errors++; $display("FAIL fill_full got=%0d/%b exp=64/1", buffer_occupancy, full); end
    drive(1, 8'hFF, 0, 8'h00, 0, 0, 0, 0, 0);
    checks++; if ({buffer_occupancy, full} !== {7'd64, 1'b1}) begin errors++; $display("FAIL fill_extra_write got=%0d/%b exp=64/1", buffer_occupancy, full); end
`ifdef USB_BUFFER_ERR_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
`endif
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0);
      checks++;
      if (tx_packet_data !== 8'(i)) begin
        errors++;
        if (bad < 4) $display("FAIL fill_drain[%0d] got=%h exp=%h", i, tx_packet_data, 8'(i));
        bad++;
      end
    end
    checks++; if ({buffer_occupancy, empty} !== {7'd0, 1'b1}) begin errors++; $display("FAIL fill_drained got=%0d/%b exp=0/1", buffer_occupancy, empty); end
  endtask

  task automatic test_flush();
    logic [7:0] rx_before;
    do_reset();
    drive(1, 8'h42, 0, 8'h00, 0, 0, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 8'($urandom), 0, 8'h00, 0, 0, 0, 0, 0);
    checks++; if (buffer_occupancy !== 7'd10) begin errors++; $display("FAIL flush_pre got=%0d exp=10", buffer_occupancy); end
    rx_before = rx_data;
    drive(0, 8'h00, 1, 8'h77, 0, 0, 1, 0, 0);
    checks++; if ({buffer_occupancy, empty} !== {7'd0, 1'b1}) begin errors++; $display("FAIL flush_occ got=%0d/%b exp=0/1", buffer_occupancy, empty); end
    drive(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);
    checks++; if ({buffer_occupancy, rx_data} !== {7'd0, 8'h42}) begin errors++; $display("FAIL flush_read_empty got=%0d/%h exp=0/42", buffer_occupancy, rx_data); end
    checks++; if (rx_data !== rx_before) begin errors++; $display("FAIL flush_rx_hold got=%h exp=%h", rx_data, rx_before); end
    // The AHB clear behaves the same way.
    drive(1, 8'h10, 0, 8'h00, 0, 0, 0, 0, 0);
    drive(1, 8'h20, 0, 8'h00, 0, 1, 0, 1, 0);
    checks++; if (dut_vec !== model_vec()) begin errors++; $display("FAIL clear_state got=%h exp=%h", dut_vec, model_vec()); end
  endtask

  task automatic test_back_to_back_wrap();
    int bad;
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 8'(i), 0, 8'h00, 0, 0, 0, 0, 0);
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      drive(1, 8'(j + 5), 0, 8'h00, 0, 1, 0, 0, 0);
      checks++;
      if ({buffer_occupancy, tx_packet_data} !== {7'd5, 8'(j)}) begin
        errors++;
        if (bad < 4) $display("FAIL wrap[%0d] got=%0d/%h exp=5/%h", j, buffer_occupancy, tx_packet_data, 8'(j));
        bad++;
      end
    end
  endtask

  task automatic test_write_priority_rst();
    do_reset();
    drive(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 0);
    checks++; if (buffer_occupancy !== 7'd1) begin errors++; $display("FAIL prio_occ got=%0d exp=1", buffer_occupancy); end
`ifdef USB_BUFFER_ERR_EN
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL prio_overflow got=%b exp=1", overflow); end
`endif
    drive(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0);
    checks++; if ({tx_packet_data, rx_data} !== {8'h11, 8'h00}) begin errors++; $display("FAIL prio_read got=%h/%h exp=11/00", tx_packet_data, rx_data); end
    for (int i = 0; i < 3; i++) drive(1, 8'($urandom), 0, 8'h00, 0, 0, 0, 0, 0);
    drive(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0);
    drive(1, 8'hEE, 0, 8'h00, 0, 1, 0, 0, 1);
    checks++; if (dut_vec !== {7'd0, 1'b0, 1'b1, 8'h00, 8'h00}) begin errors++; $display("FAIL mid_burst_rst got=%h exp=%h", dut_vec, {7'd0, 1'b0, 1'b1, 8'h00, 8'h00}); end
  endtask

  task automatic test_random();
    int bad;
    int wr_pct;
    int rd_pct;
    logic r, s, gr, gt, fl, cl;
    do_reset();
    bad = 0;
    for (int n = 0; n < 2000; n++) begin
      // Alternate fill-biased and drain-biased phases to visit full and empty.
      wr_pct = ((n / 250) % 2 == 0) ? 75 : 30;
      rd_pct = ((n / 250) % 2 == 0) ? 30 : 75;
      r  = ($urandom_range(99) < wr_pct);
      s  = ($urandom_range(99) < wr_pct);
      gr = ($urandom_range(99) < rd_pct);
      gt = ($urandom_range(99) < rd_pct);
      fl = ($urandom_range(199) == 0);
      cl = ($urandom_range(199) == 0);
      drive(r, 8'($urandom), s, 8'($urandom), gr, gt, fl, cl, ($urandom_range(499) == 0));
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        if (bad < 6) $display("FAIL random[%0d] got=%h exp=%h", n, dut_vec, model_vec());
        bad++;
      end
`ifdef USB_BUFFER_ERR_EN
      checks++;
      if ({overflow, underflow} !== {m_ovf, m_unf}) begin
        errors++;
        if (bad < 6) $display("FAIL random_flags[%0d] got=%b%b exp=%b%b", n, overflow, underflow, m_ovf, m_unf);
        bad++;
      end
`endif
    end
  endtask

  initial begin
    idle_inputs();
    m_rx  = 8'h00;
    m_tx  = 8'h00;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_rx_read();
    test_fill_overflow();
    test_flush();
    test_back_to_back_wrap();
    test_write_priority_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
